// File: rtl/dac_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dac_pattern_gen
// Description : Multi-channel DAC test-pattern generator (CONST / SAWTOOTH /
//               TRIANGLE / SQUARE) with shadow config and atomic load strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_pattern_gen #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     on_in,
    input  logic                     load_in,
    input  logic [N_CH-1:0]          ch_sel_in,
    input  logic [1:0]               mode_in,
    input  logic [DATA_W-1:0]        minval_in,
    input  logic [DATA_W-1:0]        maxval_in,
    input  logic [ACC_W-1:0]         stepsize_in,
    output logic [N_CH*DATA_W-1:0]   signal_out,
    output logic [N_CH-1:0]          wrap_out,
    output logic [N_CH-1:0]          cfg_err_out
);

    localparam int                  c_FRAC_W     = ACC_W - DATA_W;
    localparam logic [1:0]          c_MODE_CONST = 2'd0;
    localparam logic [1:0]          c_MODE_SAW   = 2'd1;
    localparam logic [1:0]          c_MODE_TRI   = 2'd2;
    localparam logic [1:0]          c_MODE_SQR   = 2'd3;
    localparam logic [c_FRAC_W-1:0] c_FRAC_ZERO  = '0;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            logic [1:0]               r_mode;
            logic signed [DATA_W-1:0] r_min;
            logic signed [DATA_W-1:0] r_max;
            logic signed [DATA_W-1:0] r_sig;
            logic [ACC_W-1:0]         r_step;
            logic signed [ACC_W-1:0]  r_acc;
            logic                     r_dir_dn;
            logic                     r_sq_lvl;
            logic                     r_err;
            logic                     r_wrap_pend;
            logic                     r_wrap;

            logic                     w_load;
            logic signed [ACC_W:0]    w_up;
            logic signed [ACC_W:0]    w_dn;
            logic signed [DATA_W:0]   w_nv_up;
            logic signed [DATA_W:0]   w_nv_dn;
            logic signed [DATA_W:0]   w_min_ext;
            logic signed [DATA_W:0]   w_max_ext;
            logic signed [ACC_W-1:0]  w_min_acc;
            logic signed [ACC_W-1:0]  w_max_acc;
            logic signed [ACC_W-1:0]  w_acc_nxt;
            logic                     w_dir_nxt;
            logic                     w_lvl_nxt;
            logic                     w_wrap_nxt;
            logic signed [DATA_W-1:0] w_sample;

            assign w_load    = load_in & ch_sel_in[k];
            // One guard bit keeps the endpoint compare from wrapping at full scale
            assign w_up      = {r_acc[ACC_W-1], r_acc} + {1'b0, r_step};
            assign w_dn      = {r_acc[ACC_W-1], r_acc} - {1'b0, r_step};
            assign w_nv_up   = w_up[ACC_W -: DATA_W+1];
            assign w_nv_dn   = w_dn[ACC_W -: DATA_W+1];
            assign w_min_ext = {r_min[DATA_W-1], r_min};
            assign w_max_ext = {r_max[DATA_W-1], r_max};
            assign w_min_acc = {r_min, c_FRAC_ZERO};
            assign w_max_acc = {r_max, c_FRAC_ZERO};

            always_comb begin
                w_acc_nxt  = r_acc;
                w_dir_nxt  = r_dir_dn;
                w_lvl_nxt  = r_sq_lvl;
                w_wrap_nxt = 1'b0;
                if ((r_step != '0) && !r_err) begin
                    case (r_mode)
                        c_MODE_CONST: w_acc_nxt = w_min_acc;
                        c_MODE_SAW, c_MODE_SQR: begin
                            if (w_nv_up > w_max_ext) begin
                                w_acc_nxt  = w_min_acc;
                                w_wrap_nxt = 1'b1;
                                if (r_mode == c_MODE_SQR) w_lvl_nxt = ~r_sq_lvl;
                            end else begin
                                w_acc_nxt = w_up[ACC_W-1:0];
                            end
                        end
                        default: begin
                            if (!r_dir_dn) begin
                                if (w_nv_up >= w_max_ext) begin
                                    w_acc_nxt  = w_max_acc;
                                    w_dir_nxt  = 1'b1;
                                    w_wrap_nxt = 1'b1;
                                end else begin
                                    w_acc_nxt = w_up[ACC_W-1:0];
                                end
                            end else begin
                                if (w_nv_dn <= w_min_ext) begin
                                    w_acc_nxt  = w_min_acc;
                                    w_dir_nxt  = 1'b0;
                                    w_wrap_nxt = 1'b1;
                                end else begin
                                    w_acc_nxt = w_dn[ACC_W-1:0];
                                end
                            end
                        end
                    endcase
                end
            end

            always_comb begin
                w_sample = r_acc[ACC_W-1 -: DATA_W];
                if (r_err || (r_mode == c_MODE_CONST)) begin
                    w_sample = r_min;
                end else if (r_mode == c_MODE_SQR) begin
                    w_sample = r_sq_lvl ? r_max : r_min;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    r_mode      <= c_MODE_CONST;
                    r_min       <= '0;
                    r_max       <= '0;
                    r_step      <= '0;
                    r_acc       <= '0;
                    r_dir_dn    <= 1'b0;
                    r_sq_lvl    <= 1'b0;
                    r_err       <= 1'b0;
                    r_wrap_pend <= 1'b0;
                    r_wrap      <= 1'b0;
                    r_sig       <= '0;
                end else begin
                    // Output stage trails the accumulator by one cycle
                    r_sig  <= w_sample;
                    r_wrap <= r_wrap_pend;
                    if (w_load) begin
                        r_mode      <= mode_in;
                        r_min       <= minval_in;
                        r_max       <= maxval_in;
                        r_step      <= stepsize_in;
                        r_acc       <= {minval_in, c_FRAC_ZERO};
                        r_dir_dn    <= 1'b0;
                        r_sq_lvl    <= 1'b0;
                        r_err       <= ($signed(minval_in) >= $signed(maxval_in));
                        r_wrap_pend <= 1'b0;
                    end else if (on_in) begin
                        r_acc       <= w_acc_nxt;
                        r_dir_dn    <= w_dir_nxt;
                        r_sq_lvl    <= w_lvl_nxt;
                        r_wrap_pend <= w_wrap_nxt;
                    end else begin
                        r_wrap_pend <= 1'b0;
                    end
                end
            end

            assign signal_out[k*DATA_W +: DATA_W] = r_sig;
            assign wrap_out[k]                    = r_wrap;
            assign cfg_err_out[k]                 = r_err;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dac_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dac_pattern_gen
// Description : Directed self-checking bench for dac_pattern_gen with an
//               arithmetic reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_pattern_gen;

    localparam int     N_CH   = 2;
    localparam int     DATA_W = 16;
    localparam int     ACC_W  = 32;
    localparam longint ONE    = 65536;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   on = 1'b0;
    logic                   load = 1'b0;
    logic [N_CH-1:0]        sel = '0;
    logic [1:0]             mode = '0;
    logic [DATA_W-1:0]      minv = '0;
    logic [DATA_W-1:0]      maxv = '0;
    logic [ACC_W-1:0]       step = '0;
    logic [N_CH*DATA_W-1:0] sig;
    logic [N_CH-1:0]        wrap;
    logic [N_CH-1:0]        err;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    dac_pattern_gen #(.N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk_in(clk), .rst_in(rst), .on_in(on), .load_in(load),
        .ch_sel_in(sel), .mode_in(mode), .minval_in(minv), .maxval_in(maxv),
        .stepsize_in(step), .signal_out(sig), .wrap_out(wrap), .cfg_err_out(err)
    );

    always #5 clk = ~clk;

    // Reference model: phase held as a plain integer in 1/65536 sample units
    int     m_mode[N_CH];
    longint m_min[N_CH], m_max[N_CH], m_step[N_CH], m_pos[N_CH];
    bit     m_dn[N_CH], m_lvl[N_CH], m_err[N_CH], m_pend[N_CH];
    longint e_sig[N_CH];
    bit     e_wrap[N_CH], e_err[N_CH];
    longint m_t;

    function automatic longint floor_units(longint x);
        if (x >= 0) return x / ONE;
        return -((-x + ONE - 1) / ONE);
    endfunction

    function automatic longint model_sample(int k);
        if (m_err[k] || m_mode[k] == 0) return m_min[k];
        if (m_mode[k] == 3) return m_lvl[k] ? m_max[k] : m_min[k];
        return floor_units(m_pos[k]);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_min[k] = 0; m_max[k] = 0; m_step[k] = 0; m_pos[k] = 0;
                m_dn[k] = 0; m_lvl[k] = 0; m_err[k] = 0; m_pend[k] = 0;
                e_sig[k] = 0; e_wrap[k] = 0;
            end else begin
                e_sig[k]  = model_sample(k);
                e_wrap[k] = m_pend[k];
                m_pend[k] = 0;
                if (load && sel[k]) begin
                    m_mode[k] = int'(mode);
                    m_min[k]  = longint'($signed(minv));
                    m_max[k]  = longint'($signed(maxv));
                    m_step[k] = longint'(step);
                    m_pos[k]  = m_min[k] * ONE;
                    m_dn[k] = 0; m_lvl[k] = 0;
                    m_err[k]  = (m_min[k] >= m_max[k]);
                end else if (on && m_step[k] != 0 && !m_err[k]) begin
                    case (m_mode[k])
                        0: m_pos[k] = m_min[k] * ONE;
                        1, 3: begin
                            m_t = m_pos[k] + m_step[k];
                            if (floor_units(m_t) > m_max[k]) begin
                                m_pos[k] = m_min[k] * ONE; m_pend[k] = 1;
                                if (m_mode[k] == 3) m_lvl[k] = !m_lvl[k];
                            end else m_pos[k] = m_t;
                        end
                        default: begin
                            if (!m_dn[k]) begin
                                m_t = m_pos[k] + m_step[k];
                                if (floor_units(m_t) >= m_max[k]) begin
                                    m_pos[k] = m_max[k] * ONE; m_dn[k] = 1; m_pend[k] = 1;
                                end else m_pos[k] = m_t;
                            end else begin
                                m_t = m_pos[k] - m_step[k];
                                if (floor_units(m_t) <= m_min[k]) begin
                                    m_pos[k] = m_min[k] * ONE; m_dn[k] = 0; m_pend[k] = 1;
                                end else m_pos[k] = m_t;
                            end
                        end
                    endcase
                end
            end
            e_err[k] = m_err[k];
        end
    end

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s ch%0d actual=%0d expected=%0d @%0t", name, k, act, exp, $time);
    endtask

    function automatic longint dut_sig(int k);
        return longint'($signed(sig[k*DATA_W +: DATA_W]));
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N_CH; k++) begin
                chk("model_sig", k, dut_sig(k), e_sig[k]);
                chk("model_wrap", k, longint'(wrap[k]), longint'(e_wrap[k]));
                chk("model_err", k, longint'(err[k]), longint'(e_err[k]));
            end
        end
    end

    task automatic do_load(input logic [N_CH-1:0] s, input int md, input int mn, input int mx,
                           input logic [ACC_W-1:0] st);
        @(negedge clk);
        load = 1'b1; sel = s; mode = 2'(md); minv = 16'(mn); maxv = 16'(mx); step = st;
        @(negedge clk);
        load = 1'b0; sel = '0;
    endtask

    int tri_tbl[14] = '{-4, -3, -2, -1, 0, 1, 2, 3, 2, 1, 0, -1, -2, -3};
    int wcnt;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_sig", 0, longint'(sig), 0);
        chk("reset_wrap", 0, longint'(wrap), 0);
        chk("reset_err", 0, longint'(err), 0);
        chk_en = 1'b1;
        rst = 1'b0;
        on = 1'b1;

        // Sawtooth on ch0
        do_load(2'b01, 1, -4, 3, 32'h0001_0000);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("saw_sig", 0, dut_sig(0), longint'((i % 8) - 4));
            chk("saw_wrap", 0, longint'(wrap[0]), (i == 8) ? 1 : 0);
        end

        // Reset mid-ramp
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_sig", 0, longint'(sig), 0);
            chk("midrst_wrap", 0, longint'(wrap), 0);
        end
        rst = 1'b0;

        // Triangle on ch1 while ch0 runs a sawtooth
        do_load(2'b01, 1, -4, 3, 32'h0001_0000);
        do_load(2'b10, 2, -4, 3, 32'h0001_0000);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tri_sig", 1, dut_sig(1), longint'(tri_tbl[i % 14]));
            chk("tri_wrap", 1, longint'(wrap[1]), (i == 7 || i == 14) ? 1 : 0);
        end

        // Square on ch0: 8 samples per level
        do_load(2'b01, 3, -100, 100, 32'h001C_0000);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("sqr_sig", 0, dut_sig(0), ((i / 8) % 2 == 1) ? 100 : -100);
            chk("sqr_wrap", 0, longint'(wrap[0]), (i % 8 == 0 && i > 0) ? 1 : 0);
        end

        // Full-scale sawtooth reaching 0x7FFF then wrapping to 0x8000
        do_load(2'b10, 1, -32768, 32767, 32'h0101_0000);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (i == 1)   chk("fs_second", 1, dut_sig(1), -32511);
            if (i == 255) chk("fs_top", 1, dut_sig(1), 32767);
            if (i == 256) begin
                chk("fs_wrap_sig", 1, dut_sig(1), -32768);
                chk("fs_wrap", 1, longint'(wrap[1]), 1);
            end
        end
        do_load(2'b10, 1, -32768, 32767, 32'h0000_0200);
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (i == 127) chk("slow_127", 1, dut_sig(1), -32768);
            if (i == 128) chk("slow_128", 1, dut_sig(1), -32767);
            if (i == 256) chk("slow_256", 1, dut_sig(1), -32766);
        end

        // Freeze
        do_load(2'b10, 2, -4, 3, 32'h0001_0000);
        repeat (5) @(negedge clk);
        on = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 1) wcnt += int'(wrap[0]) + int'(wrap[1]);
            if (i >= 1) chk("freeze_tri", 1, dut_sig(1), 1);
        end
        chk("freeze_wraps", 0, longint'(wcnt), 0);
        on = 1'b1;
        repeat (10) @(negedge clk);

        // Load coincident with reset: reset wins
        rst = 1'b1; load = 1'b1; sel = 2'b11; mode = 2'd1;
        minv = 16'd7; maxv = 16'd20; step = 32'h0001_0000;
        @(negedge clk);
        rst = 1'b0; load = 1'b0; sel = '0;
        repeat (2) @(negedge clk);
        chk("ldrst_sig", 0, longint'(sig), 0);
        chk("ldrst_err", 0, longint'(err), 0);

        // Load while frozen
        on = 1'b0;
        do_load(2'b01, 1, 10, 50, 32'h0001_0000);
        @(negedge clk);
        chk("ldoff_first", 0, dut_sig(0), 10);
        repeat (5) @(negedge clk);
        chk("ldoff_hold", 0, dut_sig(0), 10);
        on = 1'b1;
        repeat (5) @(negedge clk);

        // Config error and zero step
        do_load(2'b01, 1, 5, 5, 32'h0001_0000);
        chk("err_set", 0, longint'(err[0]), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("err_sig", 0, dut_sig(0), 5);
            chk("err_wrap", 0, longint'(wrap[0]), 0);
        end
        do_load(2'b10, 2, -3, 9, 32'h0000_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("zstep_sig", 1, dut_sig(1), -3);
            chk("zstep_wrap", 1, longint'(wrap[1]), 0);
        end
        do_load(2'b01, 1, -2, 2, 32'h0001_0000);
        chk("err_clear", 0, longint'(err[0]), 0);
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
